// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations over DEPTH stages, combinational
// stall/forward selects (zero latency); stall holds decode and injects a bubble, flush kills young entries.
module pipe_scoreboard #(
   parameter int NSRC     = 3,
   parameter int REGW     = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int FLUSH_N  = 3,
   localparam int SW      = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   input  logic [NSRC*REGW-1:0] issue_src,
   input  logic [NSRC-1:0]      issue_src_used,
   input  logic                 issue_wr,
   input  logic [REGW-1:0]      issue_wrreg,
   input  logic                 issue_is_load,
   input  logic                 flush,
   output logic                 stall,
   output logic                 issue_ack,
   output logic [NSRC*SW-1:0]   fwd_sel,
   output logic [SW-1:0]        pending_cnt
);

   typedef struct packed {
      logic            vld;
      logic            wr;
      logic [REGW-1:0] dst;
      logic [SW-1:0]   rdy;
   } ent_t;

   ent_t            ent [1:DEPTH];
   ent_t            nxt [1:DEPTH];
   logic [NSRC-1:0] hz;
   logic [SW-1:0]   cnt_nxt;

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      fwd_sel = '0;
      hz      = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = DEPTH; k >= 1; k--) begin
            if (issue_src_used[i] && ent[k].vld && ent[k].wr &&
                ent[k].dst == issue_src[i*REGW +: REGW]) begin
               hz[i]                 = (ent[k].rdy != '0);
               fwd_sel[i*SW +: SW]   = (ent[k].rdy != '0) ? '0 : SW'(k);
            end
         end
      end
   end

   assign stall     = issue_valid & (|hz);
   assign issue_ack = issue_valid & ~stall & ~flush;

   always_comb begin
      nxt[1] = '0;
      if (issue_ack) begin
         nxt[1].vld = 1'b1;
         nxt[1].wr  = issue_wr & (issue_wrreg != '0);
         nxt[1].dst = issue_wrreg;
         nxt[1].rdy = issue_is_load ? SW'(LOAD_LAT) : '0;
      end
      for (int k = 2; k <= DEPTH; k++) begin
         nxt[k] = ent[k-1];
         if (ent[k-1].rdy != '0)
            nxt[k].rdy = ent[k-1].rdy - SW'(1);
      end
      // Flush removes the post-shift young window, including what just entered stage 1.
      if (flush) begin
         for (int k = 1; k <= FLUSH_N; k++)
            nxt[k].vld = 1'b0;
      end
      cnt_nxt = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (nxt[k].vld && nxt[k].wr)
            cnt_nxt = cnt_nxt + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++)
            ent[k] <= '0;
         pending_cnt <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++)
            ent[k] <= nxt[k];
         pending_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Drives two scoreboard configurations (3/1/3 and 4/2/2) with shared stimulus against an age-based model.
module tb_pipe_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [14:0] issue_src;
   logic [2:0]  issue_src_used;
   logic        issue_wr;
   logic [4:0]  issue_wrreg;
   logic        issue_is_load;
   logic        flush;

   logic        stall_a, ack_a, stall_b, ack_b;
   logic [5:0]  fsel_a;
   logic [8:0]  fsel_b;
   logic [1:0]  pend_a;
   logic [2:0]  pend_b;

   always #5 clk = ~clk;

   pipe_scoreboard #(.NSRC(3), .REGW(5), .DEPTH(3), .LOAD_LAT(1), .FLUSH_N(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_src(issue_src),
      .issue_src_used(issue_src_used), .issue_wr(issue_wr), .issue_wrreg(issue_wrreg),
      .issue_is_load(issue_is_load), .flush(flush), .stall(stall_a), .issue_ack(ack_a),
      .fwd_sel(fsel_a), .pending_cnt(pend_a));

   pipe_scoreboard #(.NSRC(3), .REGW(5), .DEPTH(4), .LOAD_LAT(2), .FLUSH_N(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_src(issue_src),
      .issue_src_used(issue_src_used), .issue_wr(issue_wr), .issue_wrreg(issue_wrreg),
      .issue_is_load(issue_is_load), .flush(flush), .stall(stall_b), .issue_ack(ack_b),
      .fwd_sel(fsel_b), .pending_cnt(pend_b));

   // Model: list of issued register writers with issue time; stage = age since issue.
   typedef struct {
      bit v;
      int t;
      int dst;
      bit ld;
   } rec_t;

   rec_t mr [2][16];
   int   cyc;
   int   n_chk, n_err;
   bit   chk_en;
   int   cur_src [3];

   int   e_sel [2][3];
   bit   e_hz [2][3];
   bit   e_stall [2];
   bit   e_ack [2];
   int   e_pend [2];

   int   obs_sel [2][3];
   int   obs_stall [2];
   int   obs_ack [2];
   int   obs_pend [2];

   function automatic int dep(int n); return (n == 0) ? 3 : 4; endfunction
   function automatic int lat(int n); return (n == 0) ? 1 : 2; endfunction
   function automatic int fln(int n); return (n == 0) ? 3 : 2; endfunction

   function automatic int age(int n, int j);
      return cyc - mr[n][j].t + 1;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_eval(int n);
      e_stall[n] = 1'b0;
      e_pend[n]  = 0;
      for (int j = 0; j < 16; j++)
         if (mr[n][j].v && age(n, j) >= 1 && age(n, j) <= dep(n)) e_pend[n]++;
      for (int i = 0; i < 3; i++) begin
         int best, bj;
         best = 0;
         bj   = -1;
         if (issue_src_used[i] && cur_src[i] != 0) begin
            for (int j = 0; j < 16; j++) begin
               int a;
               a = age(n, j);
               if (mr[n][j].v && mr[n][j].dst == cur_src[i] && a >= 1 && a <= dep(n) &&
                   (best == 0 || a < best)) begin
                  best = a;
                  bj   = j;
               end
            end
         end
         e_hz[n][i]  = 1'b0;
         e_sel[n][i] = 0;
         if (bj >= 0) begin
            if (mr[n][bj].ld && (best - 1) < lat(n)) e_hz[n][i] = 1'b1;
            else e_sel[n][i] = best;
         end
         if (e_hz[n][i] && issue_valid) e_stall[n] = 1'b1;
      end
      e_ack[n] = issue_valid && !e_stall[n] && !flush;
   endfunction

   // Called after cyc has advanced past the edge.
   function automatic void model_edge(int n, bit r, bit ack, bit fl, bit w, int wd, bit l);
      if (!r) begin
         for (int j = 0; j < 16; j++) mr[n][j].v = 1'b0;
         return;
      end
      for (int j = 0; j < 16; j++) begin
         if (mr[n][j].v && age(n, j) > dep(n)) mr[n][j].v = 1'b0;
         if (mr[n][j].v && fl && age(n, j) <= fln(n)) mr[n][j].v = 1'b0;
      end
      if (ack && w && wd != 0) begin
         for (int j = 0; j < 16; j++) begin
            if (!mr[n][j].v) begin
               mr[n][j].v   = 1'b1;
               mr[n][j].t   = cyc;
               mr[n][j].dst = wd;
               mr[n][j].ld  = l;
               break;
            end
         end
      end
   endfunction

   task automatic step(input bit r, input bit v, input int s0, input int s1, input int s2,
                       input bit [2:0] u, input bit w, input int wd, input bit l, input bit f);
      bit ack0, ack1;
      rst_n          = r;
      issue_valid    = v;
      cur_src[0]     = s0;
      cur_src[1]     = s1;
      cur_src[2]     = s2;
      issue_src      = {5'(s2), 5'(s1), 5'(s0)};
      issue_src_used = u;
      issue_wr       = w;
      issue_wrreg    = 5'(wd);
      issue_is_load  = l;
      flush          = f;
      @(negedge clk);
      model_eval(0);
      model_eval(1);
      obs_stall[0] = int'(stall_a);
      obs_stall[1] = int'(stall_b);
      obs_ack[0]   = int'(ack_a);
      obs_ack[1]   = int'(ack_b);
      obs_pend[0]  = int'(pend_a);
      obs_pend[1]  = int'(pend_b);
      for (int i = 0; i < 3; i++) begin
         obs_sel[0][i] = int'(fsel_a[i*2 +: 2]);
         obs_sel[1][i] = int'(fsel_b[i*3 +: 3]);
      end
      if (chk_en) begin
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("stall%0d", n), obs_stall[n], int'(e_stall[n]));
            chk($sformatf("ack%0d", n), obs_ack[n], int'(e_ack[n]));
            chk($sformatf("pend%0d", n), obs_pend[n], e_pend[n]);
            for (int i = 0; i < 3; i++)
               if (!e_hz[n][i]) chk($sformatf("sel%0d_%0d", n, i), obs_sel[n][i], e_sel[n][i]);
         end
      end
      ack0 = e_ack[0];
      ack1 = e_ack[1];
      @(posedge clk);
      cyc++;
      model_edge(0, r, ack0, f, w, wd, l);
      model_edge(1, r, ack1, f, w, wd, l);
      chk_en = 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
   endtask

   initial begin
      n_chk  = 0;
      n_err  = 0;
      cyc    = 0;
      chk_en = 1'b0;
      for (int n = 0; n < 2; n++)
         for (int j = 0; j < 16; j++) mr[n][j].v = 1'b0;

      // Reset with junk inputs, then a junk cycle on an empty scoreboard.
      step(0, 1, 3, 7, 9, 3'b111, 1, 3, 1, 0);
      step(0, 1, 3, 7, 9, 3'b111, 1, 7, 1, 0);
      step(1, 1, 3, 7, 9, 3'b111, 1, 7, 1, 0);
      chk("rst_stall", obs_stall[0], 0);
      chk("rst_sel", obs_sel[0][1], 0);
      chk("rst_pend", obs_pend[0], 0);
      idle(5);

      // ALU forwarding chain on r8.
      step(1, 1, 1, 2, 0, 3'b011, 1, 8, 0, 0);
      step(1, 1, 8, 0, 0, 3'b001, 1, 10, 0, 0);
      chk("alu_sel1", obs_sel[0][0], 1);
      chk("alu_nostall", obs_stall[0], 0);
      step(1, 1, 8, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("alu_sel2", obs_sel[0][0], 2);
      step(1, 1, 8, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("alu_sel3", obs_sel[0][0], 3);
      step(1, 1, 8, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("alu_retired", obs_sel[0][0], 0);
      idle(5);

      // Load-use with LOAD_LAT=1.
      step(1, 1, 0, 0, 0, 3'b000, 1, 1, 1, 0);
      step(1, 1, 0, 1, 0, 3'b010, 1, 4, 0, 0);
      chk("lu_stall", obs_stall[0], 1);
      chk("lu_pend1", obs_pend[0], 1);
      step(1, 1, 0, 1, 0, 3'b010, 1, 4, 0, 0);
      chk("lu_unstall", obs_stall[0], 0);
      chk("lu_sel2", obs_sel[0][1], 2);
      chk("lu_pend1b", obs_pend[0], 1);
      idle(1);
      chk("lu_pend2", obs_pend[0], 2);
      idle(5);

      // LOAD_LAT=2, DEPTH=4 configuration.
      step(1, 1, 0, 0, 0, 3'b000, 1, 3, 1, 0);
      step(1, 1, 3, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("ll2_stall1", obs_stall[1], 1);
      step(1, 1, 3, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("ll2_stall2", obs_stall[1], 1);
      step(1, 1, 3, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("ll2_clear", obs_stall[1], 0);
      chk("ll2_sel3", obs_sel[1][0], 3);
      idle(5);

      // Younger unready load shadows an older ready ALU write; r0 never hazards.
      step(1, 1, 0, 0, 0, 3'b000, 1, 5, 0, 0);
      step(1, 1, 0, 0, 0, 3'b000, 1, 5, 1, 0);
      step(1, 1, 5, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("prio_stall", obs_stall[0], 1);
      idle(5);
      step(1, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0);
      step(1, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0);
      chk("r0_stall", obs_stall[0], 0);
      chk("r0_sel", obs_sel[0][0], 0);
      idle(5);

      // Flush after three writers of r9.
      for (int c = 0; c < 3; c++) step(1, 1, 0, 0, 0, 3'b000, 1, 9, 0, 0);
      step(1, 1, 0, 0, 0, 3'b000, 1, 11, 0, 1);
      chk("fl_ack", obs_ack[0], 0);
      step(1, 1, 9, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("fl_sel", obs_sel[0][0], 0);
      chk("fl_pend", obs_pend[0], 0);
      idle(5);

      // Flush during a load-use stall.
      step(1, 1, 0, 0, 0, 3'b000, 1, 12, 1, 0);
      step(1, 1, 12, 0, 0, 3'b001, 1, 13, 0, 1);
      chk("fls_stall", obs_stall[0], 1);
      chk("fls_ack", obs_ack[0], 0);
      step(1, 1, 12, 0, 0, 3'b001, 0, 0, 0, 0);
      chk("fls_nostall", obs_stall[0], 0);
      chk("fls_sel", obs_sel[0][0], 0);
      idle(5);

      // Random traffic over a small register set to provoke hazards.
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
